// File: rtl/gpio_apb_banked.sv
// Banked GPIO with a zero-wait-state APB slave, two-flop input sync and rise/fall edge interrupts.
// Define GPIO_APB_DEBOUNCE_EN to add per-pin debounce counters driven by the bank-0 DEBOUNCE threshold.
module gpio_apb_banked #(
    parameter int NrGPIOs    = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DB_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [NrGPIOs-1:0]    gpio_in_i,
    output logic [NrGPIOs-1:0]    gpio_out_o,
    output logic [NrGPIOs-1:0]    gpio_tx_en_o,
    output logic [NrGPIOs-1:0]    gpio_in_sync_o,
    output logic [NrGPIOs-1:0]    pin_interrupts_o,
    output logic                  global_interrupt_o
);
    localparam int NrBanks = (NrGPIOs + 31) / 32;

    localparam logic [3:0] REG_DIR    = 4'd0;
    localparam logic [3:0] REG_OUT    = 4'd1;
    localparam logic [3:0] REG_SET    = 4'd2;
    localparam logic [3:0] REG_CLR    = 4'd3;
    localparam logic [3:0] REG_TGL    = 4'd4;
    localparam logic [3:0] REG_IN     = 4'd5;
    localparam logic [3:0] REG_RISE   = 4'd6;
    localparam logic [3:0] REG_FALL   = 4'd7;
    localparam logic [3:0] REG_STATUS = 4'd8;
    localparam logic [3:0] REG_DB     = 4'd9;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("gpio_apb_banked: DATA_WIDTH must be 32");
        end
        if (NrGPIOs < 1 || NrGPIOs > 256) begin : g_bad_nr_gpios
            $error("gpio_apb_banked: NrGPIOs must be 1..256");
        end
        if (DB_WIDTH < 1 || DB_WIDTH > 31) begin : g_bad_db_width
            $error("gpio_apb_banked: DB_WIDTH must be 1..31");
        end
        if (ADDR_WIDTH < 12) begin : g_bad_addr_width
            $error("gpio_apb_banked: ADDR_WIDTH must be >= 12");
        end
    endgenerate

    logic [NrGPIOs-1:0]  dir_reg, dir_next;
    logic [NrGPIOs-1:0]  out_reg, out_next;
    logic [NrGPIOs-1:0]  rise_reg, rise_next;
    logic [NrGPIOs-1:0]  fall_reg, fall_next;
    logic [NrGPIOs-1:0]  status_reg, status_next;
    logic [DB_WIDTH-1:0] db_reg, db_next;
    logic [NrGPIOs-1:0]  sync1_reg, sync2_reg, in_d_reg, in_q, edge_hits;
    logic [NrGPIOs-1:0]  bank_mask, wbits, rd_vec;
    logic [NrBanks*32-1:0] rd_pad;
    logic [31:0]         rdata;
    logic [3:0]          reg_idx;
    logic [2:0]          bank;
    logic                access, err, wr;
    logic                unused_bits;

    assign reg_idx     = paddr_i[9:6];
    assign bank        = paddr_i[4:2];
    assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:10], paddr_i[5], paddr_i[1:0], pwdata_i};

    assign access = psel_i & penable_i & ~rst_i;
    assign err    = (reg_idx > REG_DB) | ({29'b0, bank} >= 32'(NrBanks)) |
                    (pwrite_i & (reg_idx == REG_IN)) | ((reg_idx == REG_DB) & (bank != 3'd0));
    assign wr     = access & pwrite_i & ~err;

    // Each pin sees only the data bit of its own bank; pins outside the addressed bank are masked off.
    for (genvar gi = 0; gi < NrGPIOs; gi++) begin : g_pin_sel
        assign bank_mask[gi] = (bank == 3'(gi / 32));
        assign wbits[gi]     = pwdata_i[gi % 32] & bank_mask[gi];
    end

    always_comb begin
        dir_next    = dir_reg;
        out_next    = out_reg;
        rise_next   = rise_reg;
        fall_next   = fall_reg;
        db_next     = db_reg;
        status_next = status_reg | edge_hits;
        if (wr) begin
            case (reg_idx)
                REG_DIR:    dir_next    = (dir_reg & ~bank_mask) | wbits;
                REG_OUT:    out_next    = (out_reg & ~bank_mask) | wbits;
                REG_SET:    out_next    = out_reg | wbits;
                REG_CLR:    out_next    = out_reg & ~wbits;
                REG_TGL:    out_next    = out_reg ^ wbits;
                REG_RISE:   rise_next   = (rise_reg & ~bank_mask) | wbits;
                REG_FALL:   fall_next   = (fall_reg & ~bank_mask) | wbits;
                REG_STATUS: status_next = (status_reg & ~wbits) | edge_hits;
                REG_DB:     db_next     = pwdata_i[DB_WIDTH-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_reg    <= '0;
            out_reg    <= '0;
            rise_reg   <= '0;
            fall_reg   <= '0;
            status_reg <= '0;
            db_reg     <= '0;
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            in_d_reg   <= '0;
        end else begin
            dir_reg    <= dir_next;
            out_reg    <= out_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            status_reg <= status_next;
            db_reg     <= db_next;
            sync1_reg  <= gpio_in_i;
            sync2_reg  <= sync1_reg;
            in_d_reg   <= in_q;
        end
    end

`ifdef GPIO_APB_DEBOUNCE_EN
    logic [DB_WIDTH:0] db_limit;
    assign db_limit = (db_reg == '0) ? (DB_WIDTH+1)'(1) : {1'b0, db_reg};

    // The count clears on agreement or on acceptance, so it never exceeds the threshold.
    for (genvar gi = 0; gi < NrGPIOs; gi++) begin : g_debounce
        logic [DB_WIDTH-1:0] cnt_reg;
        logic [DB_WIDTH:0]   cnt_inc;
        logic                q_reg;
        assign cnt_inc = {1'b0, cnt_reg} + (DB_WIDTH+1)'(1);
        assign in_q[gi] = q_reg;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_reg <= '0;
                q_reg   <= 1'b0;
            end else if (sync2_reg[gi] == q_reg) begin
                cnt_reg <= '0;
            end else if (cnt_inc >= db_limit) begin
                cnt_reg <= '0;
                q_reg   <= sync2_reg[gi];
            end else begin
                cnt_reg <= cnt_inc[DB_WIDTH-1:0];
            end
        end
    end
`else
    logic [NrGPIOs-1:0] q_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_reg <= '0;
        end else begin
            q_reg <= sync2_reg;
        end
    end
    assign in_q = q_reg;
`endif

    assign edge_hits = (in_q & ~in_d_reg & rise_reg) | (~in_q & in_d_reg & fall_reg);

    always_comb begin
        rd_vec = '0;
        case (reg_idx)
            REG_DIR:    rd_vec = dir_reg;
            REG_OUT:    rd_vec = out_reg;
            REG_IN:     rd_vec = in_q;
            REG_RISE:   rd_vec = rise_reg;
            REG_FALL:   rd_vec = fall_reg;
            REG_STATUS: rd_vec = status_reg;
            default:    rd_vec = '0;
        endcase
        rd_pad = '0;
        rd_pad[NrGPIOs-1:0] = rd_vec;
        rdata = '0;
        for (int b = 0; b < NrBanks; b++) begin
            if (bank == 3'(b)) rdata = rd_pad[b*32 +: 32];
        end
        if (reg_idx == REG_DB) rdata = 32'(db_reg);
        prdata_o = (access & ~pwrite_i & ~err) ? rdata : 32'd0;
    end

    assign pready_o           = psel_i & penable_i & ~rst_i;
    assign pslverr_o          = access & err;
    assign gpio_out_o         = out_reg;
    assign gpio_tx_en_o       = dir_reg;
    assign gpio_in_sync_o     = in_q;
    assign pin_interrupts_o   = status_reg & (rise_reg | fall_reg);
    assign global_interrupt_o = |pin_interrupts_o;
endmodule

// File: tb/tb_gpio_apb_banked.sv
// Scoreboard bench for gpio_apb_banked with 40 pins: APB responses are queued at issue and
// checked by a monitor in the access phase; pin-side timing is checked directly.
`timescale 1ns/1ps
module tb_gpio_apb_banked;
    localparam int N = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   paddr = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [N-1:0]  gpio_in = '0;
    logic [N-1:0]  gpio_out, gpio_tx_en, gpio_in_sync, pin_int;
    logic          global_int;

    gpio_apb_banked #(.NrGPIOs(N)) dut (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out),
        .gpio_tx_en_o(gpio_tx_en), .gpio_in_sync_o(gpio_in_sync),
        .pin_interrupts_o(pin_int), .global_interrupt_o(global_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_read;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: every access phase outside reset consumes one expected response.
    always @(negedge clk) begin
        if (psel && penable && !rst) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_txn: addr=%h pslverr=%b prdata=%h, required no access", paddr, pslverr, prdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (pready !== 1'b1 || pslverr !== mon_e.err || (mon_e.is_read && prdata !== mon_e.rdata)) begin
                    errors++;
                    $display("FAIL %s: pready=%b pslverr=%b prdata=%h, required pready=1 pslverr=%b prdata=%h",
                             mon_e.name, pready, pslverr, prdata, mon_e.err, mon_e.rdata);
                end else begin
                    $display("txn %s: %s addr=%h pslverr=%b prdata=%h", mon_e.name,
                             mon_e.is_read ? "rd" : "wr", paddr, pslverr, prdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("chk %s: %0h", name, act);
        end
    endtask

    function automatic logic [11:0] addr_of(input int r, input int b);
        return 12'((r << 6) | (b << 2));
    endfunction

    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_err, input string name);
        exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {20'b0, addr}; pwdata = wdata;
        e.name = name; e.is_read = !wr; e.rdata = exp_rd; e.err = exp_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input int r, input int b, input logic [31:0] d, input string name);
        apb(1'b1, addr_of(r, b), d, 32'd0, 1'b0, name);
    endtask

    task automatic rd(input int r, input int b, input logic [31:0] exp, input string name);
        apb(1'b0, addr_of(r, b), 32'd0, exp, 1'b0, name);
    endtask

    // Pulse pin 0 high for 'width' sampled edges; report first edge and number of edges with in_sync[0] high.
    task automatic pulse(input int width, output int first_hi, output int hi_cnt);
        first_hi = -1;
        hi_cnt = 0;
        @(posedge clk); #1;
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == width) gpio_in[0] = 1'b0;
            if (gpio_in_sync[0]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k;
            end
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    int f4, n4, f6, n6;

    initial begin
        // Reset values, with an access held open during reset
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = {20'b0, addr_of(1, 0)};
        #2;
        check("rst_pready", pready, 0);
        check("rst_prdata_err", {prdata, 31'b0, pslverr}, 0);
        repeat (3) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        check("rst_outs", {gpio_out, gpio_tx_en}, 0);
        check("rst_ins", {pin_int, gpio_in_sync, 23'b0, global_int}, 0);
        rst = 1'b0;

        // Reset asserted in the middle of an OUT write
        wr(0, 0, 32'hFF, "dir_b0");
        wr(1, 0, 32'h0F, "out_b0");
        check("gpio_out_b0", gpio_out[7:0], 8'h0F);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = {20'b0, addr_of(1, 0)}; pwdata = 32'hF0;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_pready", pready, 0);
        check("midrst_outs", {gpio_out, gpio_tx_en}, 0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_global", global_int, 0);
        rd(1, 0, 32'h0, "out_after_rst");
        rd(0, 0, 32'h0, "dir_after_rst");

        // Atomic output operations in bank 1
        wr(0, 1, 32'hFF, "dir_b1");
        wr(1, 1, 32'hA5, "out_b1");
        wr(2, 1, 32'h0A, "set_b1");
        wr(3, 1, 32'h01, "clr_b1");
        wr(4, 1, 32'hF0, "tgl_b1");
        rd(1, 1, 32'h5E, "out_b1_rd");
        rd(2, 1, 32'h0, "set_b1_rd");
        check("gpio_out_b1", gpio_out[39:32], 8'h5E);
        check("tx_en_b1", gpio_tx_en[39:32], 8'hFF);
        check("gpio_out_b0_clear", gpio_out[31:0], 0);
        wr(0, 1, 32'hFFFF_FFFF, "dir_b1_all");
        rd(0, 1, 32'h0000_00FF, "dir_b1_upper_zero");
        apb(1'b0, addr_of(1, 1) | 12'h023, 32'd0, 32'h5E, 1'b0, "out_b1_alias");

        // Address errors: no side effects, read data 0
        apb(1'b0, addr_of(1, 2), 32'd0, 32'd0, 1'b1, "err_bank2_rd");
        apb(1'b1, addr_of(1, 2), 32'hFF, 32'd0, 1'b1, "err_bank2_wr");
        apb(1'b0, addr_of(10, 0), 32'd0, 32'd0, 1'b1, "err_reg10");
        apb(1'b1, addr_of(5, 0), 32'hFF, 32'd0, 1'b1, "err_wr_in");
        apb(1'b0, addr_of(9, 1), 32'd0, 32'd0, 1'b1, "err_db_b1_rd");
        apb(1'b1, addr_of(9, 1), 32'h7, 32'd0, 1'b1, "err_db_b1_wr");
        rd(1, 1, 32'h5E, "out_b1_unchanged");
        rd(9, 0, 32'h0, "db_b0_unchanged");
        rd(5, 0, 32'h0, "in_b0_rd");

        // Rise interrupt on pin 3 with T = 0
        wr(6, 0, 32'h8, "rise_en_b0");
        @(posedge clk); #1;
        gpio_in[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_sync3_lat3", gpio_in_sync[3], 1);
        check("irq_not_yet", global_int, 0);
        @(posedge clk); #1;
        check("irq_edge4", {pin_int[3], global_int}, 2'b11);
        rd(8, 0, 32'h8, "status_set");
        wr(8, 0, 32'h8, "status_w1c");
        rd(8, 0, 32'h0, "status_cleared");
        check("irq_cleared", global_int, 0);
        gpio_in[3] = 1'b0;
        repeat (6) @(posedge clk);
        rd(8, 0, 32'h0, "fall_not_enabled");
        @(posedge clk); #1;
        gpio_in[3] = 1'b1;
        @(posedge clk);
        wr(8, 0, 32'h8, "w1c_vs_edge");
        rd(8, 0, 32'h8, "status_set_wins");
        check("irq_set_wins", global_int, 1);
        wr(8, 0, 32'h8, "status_w1c2");
        rd(8, 0, 32'h0, "status_cleared2");

        // Debounce filtering with T = 5
        wr(9, 0, 32'h5, "db_thresh");
        rd(9, 0, 32'h5, "db_thresh_rd");
        wr(6, 0, 32'h1, "rise_en_pin0");
        pulse(4, f4, n4);
`ifdef GPIO_APB_DEBOUNCE_EN
        check("pulse4_first", 64'(f4), 64'(-1));
        check("pulse4_hicnt", 64'(n4), 0);
        rd(8, 0, 32'h0, "pulse4_no_irq");
`else
        check("pulse4_first", 64'(f4), 3);
        check("pulse4_hicnt", 64'(n4), 4);
        rd(8, 0, 32'h1, "pulse4_irq");
        wr(8, 0, 32'h1, "pulse4_w1c");
`endif
        pulse(6, f6, n6);
`ifdef GPIO_APB_DEBOUNCE_EN
        check("pulse6_first", 64'(f6), 7);
`else
        check("pulse6_first", 64'(f6), 3);
`endif
        check("pulse6_hicnt", 64'(n6), 6);
        rd(8, 0, 32'h1, "pulse6_irq");
        rd(5, 0, 32'h8, "in_settled");

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
